// File: rtl/fifo_fwft_upsizer.sv
// fifo_fwft_upsizer: pops DATA_WIDTH words from a first-word-fall-through FIFO
// and packs RATIO consecutive words into one wide word on a valid/ready stream.
// Lane 0 (the oldest word) sits in the LSBs of dout.
//
// Output handshake: dout/valid form a registered source. A word transfers on
// any rising clk edge where valid & ready; while valid & !ready, dout and valid
// hold stable. On the FIFO side, rd_en is combinational and the word on din is
// consumed at every rising edge where rd_en is 1.
//
// Optional build macro FIFO_FWFT_UPSIZER_FLUSH_EN adds a flush request input
// and a per-lane keep output, so that a partially filled word can be emitted.
module fifo_fwft_upsizer #(
  parameter int DATA_WIDTH = 16,
  parameter int RATIO = 2,
  localparam int OUT_WIDTH = DATA_WIDTH * RATIO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  empty,
  output logic                  rd_en,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  valid,
  input  logic                  ready
`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
  ,
  input  logic                  flush,
  output logic [RATIO-1:0]      keep
`endif
);

  localparam int CNT_W = $clog2(RATIO);
  localparam int ACC_W = OUT_WIDTH - DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_W-1:0]     r_acc;
  logic [OUT_WIDTH-1:0] r_dout;
  logic                 r_valid;

  logic                 w_slot_free;
  logic                 w_last;
  logic                 w_pop;
  logic                 w_load;
  logic [OUT_WIDTH-1:0] w_load_word;

  // The output register can take a new word when it is empty or being drained.
  assign w_slot_free = !r_valid || ready;
  assign w_last      = (r_cnt == LAST);
  // Lanes below the last one keep filling under backpressure; the final lane
  // is only popped when the completed word has somewhere to go.
  assign w_pop       = rst && !empty && (!w_last || w_slot_free);
  assign rd_en       = w_pop;

`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
  logic [OUT_WIDTH-1:0] w_flush_word;
  logic [RATIO-1:0]     w_flush_keep;
  logic                 w_flush_fire;
  logic [RATIO-1:0]     r_keep;

  // Flush only acts when there is something to emit and the slot is free;
  // otherwise the level request simply waits.
  assign w_flush_fire = flush && w_slot_free && ((r_cnt != '0) || w_pop);

  // Build the partial word: filled lanes from acc, the lane being popped this
  // cycle from din, everything above it zero.
  always_comb begin
    w_flush_word = '0;
    w_flush_keep = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (CNT_W'(i) < r_cnt) begin
        w_flush_word[i*DATA_WIDTH +: DATA_WIDTH] = r_acc[i*DATA_WIDTH +: DATA_WIDTH];
        w_flush_keep[i] = 1'b1;
      end else if ((CNT_W'(i) == r_cnt) && w_pop) begin
        w_flush_word[i*DATA_WIDTH +: DATA_WIDTH] = din;
        w_flush_keep[i] = 1'b1;
      end
    end
    if (w_last && w_pop) begin
      w_flush_word[OUT_WIDTH-1 -: DATA_WIDTH] = din;
      w_flush_keep[RATIO-1] = 1'b1;
    end
  end

  assign w_load      = w_flush_fire || (w_pop && w_last);
  assign w_load_word = w_flush_fire ? w_flush_word : {din, r_acc};

  // keep marks the lanes of the held word that carry real data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_keep <= '0;
    end else if (w_load) begin
      r_keep <= w_flush_fire ? w_flush_keep : '1;
    end
  end

  assign keep = r_keep;
`else
  assign w_load      = w_pop && w_last;
  assign w_load_word = {din, r_acc};
`endif

  // Accumulate popped words into their lane until the final lane arrives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
    end else begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (w_pop && !w_last && (r_cnt == CNT_W'(i))) begin
          r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= din;
        end
      end
    end
  end

  // Lane counter: advance on each pop, wrap only when a word is emitted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output register: load a finished word, otherwise drop valid on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_dout  <= w_load_word;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;

endmodule

// File: tb/tb_fifo_fwft_upsizer.sv
// Directed testbench for fifo_fwft_upsizer (DATA_WIDTH=16, RATIO=2), with an
// extra RATIO=4 instance exercising flush/keep when FIFO_FWFT_UPSIZER_FLUSH_EN
// is defined.
module tb_fifo_fwft_upsizer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- FWFT FIFO model ----------------
  logic [15:0] fifo_mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        pop_s  = 1'b0;
  int          pop_cnt = 0;

  logic [15:0] din;
  logic        empty;
  logic        ready = 1'b0;
  logic        rd_en;
  logic [31:0] dout;
  logic        valid;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  assign empty = (wr_ptr == rd_ptr);
  assign din   = fifo_mem[rd_ptr[9:0]];

`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
  logic       flush0 = 1'b0;
  logic [1:0] keep2;
`endif

  fifo_fwft_upsizer #(.DATA_WIDTH(16), .RATIO(2)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .empty (empty),
    .rd_en (rd_en),
    .dout  (dout),
    .valid (valid),
    .ready (ready)
`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
    ,
    .flush (flush0),
    .keep  (keep2)
`endif
  );

`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
  logic [15:0] f_din   = 16'h0;
  logic        f_empty = 1'b1;
  logic        f_ready = 1'b0;
  logic        f_flush = 1'b0;
  logic        f_rd_en;
  logic [63:0] f_dout;
  logic        f_valid;
  logic [3:0]  f_keep;

  fifo_fwft_upsizer #(.DATA_WIDTH(16), .RATIO(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .din   (f_din),
    .empty (f_empty),
    .rd_en (f_rd_en),
    .dout  (f_dout),
    .valid (f_valid),
    .ready (f_ready),
    .flush (f_flush),
    .keep  (f_keep)
  );
`endif

  // Sample between edges: note pending pop and accepted output words.
  always @(negedge clk) begin
    pop_s = rd_en;
    if (rd_en) pop_cnt++;
    if (valid && ready) got_q.push_back(dout);
  end

  // FIFO read pointer advances on the edge that consumes the word.
  always @(posedge clk) begin
    if (pop_s) rd_ptr <= rd_ptr + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr[9:0]] = w;
    wr_ptr++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 00000000", dout); end
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    ready = 1'b1;
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e1: got %0b expected 0", valid); end
    tick();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h22221111) begin
      errors++; $display("FAIL basic_word0: got valid=%0b dout=%h expected 1/22221111", valid, dout);
    end
`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
    checks++;
    if (keep2 !== 2'b11) begin errors++; $display("FAIL basic_keep: got %b expected 11", keep2); end
`endif
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e3: got %0b expected 0", valid); end
    tick();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h44443333) begin
      errors++; $display("FAIL basic_word1: got valid=%0b dout=%h expected 1/44443333", valid, dout);
    end
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL basic_rd_en_empty: got %0b expected 0", rd_en); end
    tick();
    checks++;
    if (valid !== 1'b0 || dout !== 32'h44443333) begin
      errors++; $display("FAIL basic_after_accept: got valid=%0b dout=%h expected 0/44443333", valid, dout);
    end
  endtask

  task automatic test_stream();
    logic [15:0] words [128];
    got_q.delete();
    exp_q.delete();
    ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      words[i] = 16'($urandom_range(0, 65535));
      push(words[i]);
    end
    for (int i = 0; i < 64; i++) exp_q.push_back({words[2*i+1], words[2*i]});
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!empty) begin
        checks++;
        if (rd_en !== 1'b1) begin errors++; $display("FAIL stream_rd_en cyc %0d: got %0b expected 1", cyc, rd_en); end
      end
      if (got_q.size() >= 64) break;
      tick();
    end
    checks++;
    if (got_q.size() != 64) begin
      errors++; $display("FAIL stream_count: got %0d words expected 64", got_q.size());
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stream_word %0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int p0;
    ready = 1'b0;
    push(16'h0101); push(16'h0202); push(16'h0303);
    push(16'h0404); push(16'h0505); push(16'h0606);
    p0 = pop_cnt;
    tick();
    tick();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h02020101) begin
      errors++; $display("FAIL bp_first: got valid=%0b dout=%h expected 1/02020101", valid, dout);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || dout !== 32'h02020101) begin
        errors++; $display("FAIL bp_hold %0d: got valid=%0b dout=%h expected 1/02020101", k, valid, dout);
      end
    end
    checks++;
    if (pop_cnt - p0 != 3) begin errors++; $display("FAIL bp_pops: got %0d expected 3", pop_cnt - p0); end
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en_stalled: got %0b expected 0", rd_en); end
    ready = 1'b1;
    #1;
    checks++;
    if (rd_en !== 1'b1) begin errors++; $display("FAIL bp_rd_en_release: got %0b expected 1", rd_en); end
    tick();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h04040303) begin
      errors++; $display("FAIL bp_accept_and_load: got valid=%0b dout=%h expected 1/04040303", valid, dout);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b expected 0", valid); end
    tick();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h06060505) begin
      errors++; $display("FAIL bp_last_word: got valid=%0b dout=%h expected 1/06060505", valid, dout);
    end
    tick();
  endtask

  task automatic test_empty_mid_word();
    int p0;
    ready = 1'b1;
    push(16'hABCD);
    tick();
    p0 = pop_cnt;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({valid, rd_en} !== 2'b00) begin
        errors++; $display("FAIL empty_wait %0d: got valid,rd_en=%b expected 00", k, {valid, rd_en});
      end
    end
    checks++;
    if (pop_cnt != p0) begin errors++; $display("FAIL empty_pops: got %0d expected 0", pop_cnt - p0); end
    push(16'h1234);
    tick();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h1234ABCD) begin
      errors++; $display("FAIL empty_resume: got valid=%0b dout=%h expected 1/1234abcd", valid, dout);
    end
    tick();
  endtask

  task automatic test_reset_mid_word();
    int p0;
    ready = 1'b0;
    push(16'h0A0A); push(16'h0B0B); push(16'h0C0C);
    repeat (4) tick();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h0B0B0A0A) begin
      errors++; $display("FAIL rst_pre: got valid=%0b dout=%h expected 1/0b0b0a0a", valid, dout);
    end
    push(16'h5555); push(16'h6666);
    ready = 1'b1;
    rst = 1'b0;
    p0 = pop_cnt;
    #1;
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b expected 0", rd_en); end
    tick();
    rst = 1'b1;
    checks++;
    if (valid !== 1'b0 || dout !== 32'h0) begin
      errors++; $display("FAIL rst_cleared: got valid=%0b dout=%h expected 0/00000000", valid, dout);
    end
    checks++;
    if (pop_cnt != p0) begin errors++; $display("FAIL rst_no_pop: got %0d pops expected 0", pop_cnt - p0); end
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL rst_half: got %0b expected 0", valid); end
    tick();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h66665555) begin
      errors++; $display("FAIL rst_fresh_word: got valid=%0b dout=%h expected 1/66665555", valid, dout);
    end
    tick();
  endtask

`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
  task automatic test_flush();
    f_ready = 1'b1;
    f_empty = 1'b0;
    f_din = 16'hAAAA;
    #1;
    checks++;
    if (f_rd_en !== 1'b1) begin errors++; $display("FAIL flush_rd_en: got %0b expected 1", f_rd_en); end
    tick();
    f_din = 16'hBBBB;
    tick();
    f_empty = 1'b1;
    f_flush = 1'b1;
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_dout !== 64'h0000_0000_BBBB_AAAA || f_keep !== 4'b0011) begin
      errors++; $display("FAIL flush_partial: got valid=%0b dout=%h keep=%b expected 1/00000000bbbbaaaa/0011", f_valid, f_dout, f_keep);
    end
    f_flush = 1'b0;
    tick();
    checks++;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL flush_accept: got %0b expected 0", f_valid); end
    f_flush = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (f_valid !== 1'b0) begin errors++; $display("FAIL flush_cnt0 %0d: got %0b expected 0", k, f_valid); end
    end
    // flush while a word is popped at cnt=0
    f_empty = 1'b0;
    f_din = 16'h1111;
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_dout !== 64'h0000_0000_0000_1111 || f_keep !== 4'b0001) begin
      errors++; $display("FAIL flush_with_pop: got valid=%0b dout=%h keep=%b expected 1/0000000000001111/0001", f_valid, f_dout, f_keep);
    end
    f_empty = 1'b1;
    f_flush = 1'b0;
    tick();
    // full word
    f_empty = 1'b0;
    f_din = 16'hCCCC; tick();
    f_din = 16'hDDDD; tick();
    f_din = 16'hEEEE; tick();
    f_din = 16'hFFFF; tick();
    f_empty = 1'b1;
    checks++;
    if (f_valid !== 1'b1 || f_dout !== 64'hFFFF_EEEE_DDDD_CCCC || f_keep !== 4'b1111) begin
      errors++; $display("FAIL flush_full_word: got valid=%0b dout=%h keep=%b expected 1/ffffeeeeddddcccc/1111", f_valid, f_dout, f_keep);
    end
    // deferred flush under backpressure
    f_ready = 1'b0;
    f_empty = 1'b0;
    f_din = 16'h7777;
    f_flush = 1'b1;
    tick();
    f_empty = 1'b1;
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_dout !== 64'hFFFF_EEEE_DDDD_CCCC) begin
      errors++; $display("FAIL flush_deferred_hold: got valid=%0b dout=%h expected 1/ffffeeeeddddcccc", f_valid, f_dout);
    end
    f_ready = 1'b1;
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_dout !== 64'h0000_0000_0000_7777 || f_keep !== 4'b0001) begin
      errors++; $display("FAIL flush_deferred_fire: got valid=%0b dout=%h keep=%b expected 1/0000000000007777/0001", f_valid, f_dout, f_keep);
    end
    f_flush = 1'b0;
    tick();
    checks++;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL flush_final_drain: got %0b expected 0", f_valid); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) fifo_mem[i] = 16'h0;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_empty_mid_word();
    test_reset_mid_word();
`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
    test_flush();
`endif
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
